// File: rtl/demux_1_8_sched_if.sv
// Stream and channel-side signals of the 1:8 demux scheduler.
// master = upstream/downstream environment, slave = scheduler.
interface demux_1_8_sched_if #(
  parameter int DW    = 8,
  parameter int DROPW = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [2:0]       in_dest;
  logic             mode;
  logic [7:0]       chan_en;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [DW-1:0]    out_data;
  logic [2:0]       s;
  logic             busy;
  logic [DROPW-1:0] drop_cnt;

  modport master (
    output in_valid, in_data, in_dest, mode, chan_en, out_ready,
    input  in_ready, out_valid, out_data, s, busy, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_dest, mode, chan_en, out_ready,
    output in_ready, out_valid, out_data, s, busy, drop_cnt
  );
endinterface

// File: rtl/demux_1_8_sched.sv
// Scheduler / flow-control front end for the 1:8 demux: picks a channel per
// word (addressed or round-robin), holds it until accepted, counts drops.
//
// state | meaning
// IDLE  | no word held
// HOLD  | word held for channel s, out_valid[s] asserted
module demux_1_8_sched #(
  parameter int DW    = 8,
  parameter int DROPW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1_8_sched_if.slave     bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DW-1:0]    data_q;
  logic [2:0]       s_q;
  logic [2:0]       rr_ptr;
  logic [DROPW-1:0] drop_q;

  logic       rr_found;
  logic [2:0] rr_dest;
  logic [2:0] dest;
  logic       dest_ok;
  logic       rr_stall;
  logic       in_ready;
  logic       accept;
  logic       load;
  logic       drop;
  logic       xfer;

  // Cyclic first-enabled search starting at rr_ptr.
  always_comb begin
    logic [2:0] idx;
    rr_found = 1'b0;
    rr_dest  = 3'd0;
    idx      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = rr_ptr + i[2:0];
      if (!rr_found && bus.chan_en[idx]) begin
        rr_found = 1'b1;
        rr_dest  = idx;
      end
    end
  end

  always_comb begin
    if (bus.mode) begin
      dest    = rr_dest;
      dest_ok = rr_found;
    end else begin
      dest    = bus.in_dest;
      dest_ok = bus.chan_en[bus.in_dest];
    end
  end

  assign rr_stall = bus.mode && (bus.chan_en == 8'h00);
  assign xfer     = (state == HOLD) && bus.out_ready[s_q];
  assign in_ready = ((state == IDLE) || bus.out_ready[s_q]) && !rr_stall;
  assign accept   = bus.in_valid && in_ready;
  assign load     = accept && dest_ok;
  assign drop     = accept && !dest_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A drop while HOLD is only possible alongside a completing transfer.
  always_comb begin
    state_nxt = state;
    if (load)              state_nxt = HOLD;
    else if (xfer || drop) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      s_q    <= 3'd0;
      rr_ptr <= 3'd0;
      drop_q <= '0;
    end else begin
      if (load) begin
        data_q <= bus.in_data;
        s_q    <= dest;
        if (bus.mode) rr_ptr <= dest + 3'd1;
      end
      if (drop && (drop_q != {DROPW{1'b1}})) drop_q <= drop_q + DROPW'(1);
    end
  end

  always_comb begin
    bus.out_valid = 8'h00;
    bus.busy      = 1'b0;
    if (state == HOLD) begin
      bus.out_valid = 8'h01 << s_q;
      bus.busy      = 1'b1;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.out_data = data_q;
  assign bus.s        = s_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_1_8_sched.sv
// Directed bench for demux_1_8_sched with hand-computed expectations.
module tb_demux_1_8_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  demux_1_8_sched_if #(.DW(8), .DROPW(8)) bif ();

  demux_1_8_sched #(.DW(8), .DROPW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rr_exp [6];
    rr_exp = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2};

    bif.in_valid  = 1'b0;
    bif.in_data   = 8'h00;
    bif.in_dest   = 3'd0;
    bif.mode      = 1'b0;
    bif.chan_en   = 8'hFF;
    bif.out_ready = 8'hFF;

    // reset state
    #12;
    chk("rst_out_valid", 32'(bif.out_valid), 32'h00);
    chk("rst_busy",      32'(bif.busy),      32'h0);
    chk("rst_s",         32'(bif.s),         32'h0);
    chk("rst_drop",      32'(bif.drop_cnt),  32'h0);
    chk("rst_data",      32'(bif.out_data),  32'h00);
    rst = 1'b0;
    tick();

    // addressed, back-to-back pass-through
    for (int i = 0; i < 8; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 8'(8'h10 + i);
      bif.in_dest  = 3'(i);
      #1;
      chk("b2b_in_ready", 32'(bif.in_ready), 32'h1);
      tick();
      chk("b2b_out_valid", 32'(bif.out_valid), 32'(8'h01 << i));
      chk("b2b_s",         32'(bif.s),         32'(i));
      chk("b2b_data",      32'(bif.out_data),  32'(8'h10 + i));
    end
    bif.in_valid = 1'b0;
    tick();
    chk("b2b_idle_valid", 32'(bif.out_valid), 32'h00);
    chk("b2b_idle_s",     32'(bif.s),         32'h7);
    chk("b2b_drop",       32'(bif.drop_cnt),  32'h0);

    // stall on channel 3
    bif.out_ready = 8'hF7;
    bif.in_valid  = 1'b1;
    bif.in_data   = 8'hA5;
    bif.in_dest   = 3'd3;
    tick();
    chk("stall_valid", 32'(bif.out_valid), 32'h08);
    chk("stall_busy",  32'(bif.busy),      32'h1);
    bif.in_data = 8'h5A;
    bif.in_dest = 3'd1;
    #1;
    chk("stall_in_ready", 32'(bif.in_ready), 32'h0);
    tick();
    chk("stall_hold_valid", 32'(bif.out_valid), 32'h08);
    chk("stall_hold_data",  32'(bif.out_data),  32'hA5);
    chk("stall_in_ready2",  32'(bif.in_ready),  32'h0);
    bif.out_ready = 8'hFF;
    #1;
    chk("release_in_ready", 32'(bif.in_ready), 32'h1);
    tick();
    chk("release_valid", 32'(bif.out_valid), 32'h02);
    chk("release_data",  32'(bif.out_data),  32'h5A);
    chk("release_s",     32'(bif.s),         32'h1);
    bif.in_valid = 1'b0;
    tick();
    chk("release_idle", 32'(bif.busy), 32'h0);

    // drops to disabled channel 3, then saturation
    bif.chan_en  = 8'hF7;
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h33;
    bif.in_dest  = 3'd3;
    tick();
    chk("drop_valid", 32'(bif.out_valid), 32'h00);
    chk("drop_cnt1",  32'(bif.drop_cnt),  32'h01);
    chk("drop_s",     32'(bif.s),         32'h1);
    repeat (253) @(posedge clk);
    #1;
    chk("drop_cnt254", 32'(bif.drop_cnt), 32'hFE);
    repeat (46) @(posedge clk);
    #1;
    chk("drop_sat", 32'(bif.drop_cnt), 32'hFF);
    chk("drop_data_kept", 32'(bif.out_data), 32'h5A);
    bif.in_valid = 1'b0;
    tick();

    // round-robin over 1010_0101
    bif.mode    = 1'b1;
    bif.chan_en = 8'b1010_0101;
    for (int i = 0; i < 6; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 8'(8'h60 + i);
      tick();
      chk("rr_s",     32'(bif.s),         32'(rr_exp[i]));
      chk("rr_valid", 32'(bif.out_valid), 32'(8'h01 << rr_exp[i]));
    end
    bif.in_valid = 1'b0;
    tick();

    // round-robin with nothing enabled, then only channel 6
    bif.chan_en  = 8'h00;
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h77;
    #1;
    chk("rr_none_ready", 32'(bif.in_ready), 32'h0);
    tick();
    chk("rr_none_busy",  32'(bif.busy),      32'h0);
    chk("rr_none_valid", 32'(bif.out_valid), 32'h00);
    bif.chan_en = 8'h40;
    #1;
    chk("rr_ch6_ready", 32'(bif.in_ready), 32'h1);
    tick();
    chk("rr_ch6_valid", 32'(bif.out_valid), 32'h40);
    chk("rr_ch6_s",     32'(bif.s),         32'h6);
    bif.in_valid = 1'b0;
    tick();

    // async reset while holding channel 4
    bif.mode      = 1'b0;
    bif.chan_en   = 8'hFF;
    bif.out_ready = 8'h00;
    bif.in_valid  = 1'b1;
    bif.in_data   = 8'h44;
    bif.in_dest   = 3'd4;
    tick();
    chk("pre_rst_valid", 32'(bif.out_valid), 32'h10);
    bif.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bif.out_valid), 32'h00);
    chk("arst_busy",  32'(bif.busy),      32'h0);
    chk("arst_s",     32'(bif.s),         32'h0);
    chk("arst_drop",  32'(bif.drop_cnt),  32'h00);
    #3;
    rst = 1'b0;
    tick();

    // resume in round-robin: pointer must be back at 0
    bif.out_ready = 8'hFF;
    bif.mode      = 1'b1;
    bif.in_valid  = 1'b1;
    bif.in_data   = 8'h99;
    tick();
    chk("resume_valid", 32'(bif.out_valid), 32'h01);
    chk("resume_data",  32'(bif.out_data),  32'h99);
    bif.in_valid = 1'b0;
    tick();
    chk("resume_idle", 32'(bif.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
